// File: rtl/al4s3b_fpga_wb_interconnect_if.sv
// Wishbone bus bundle between one master and the interconnect's slave channels.
// The slave modport is the interconnect's view and the master modport is the upstream side.
interface al4s3b_fpga_wb_interconnect_if #(
    parameter int unsigned APERWIDTH  = 17,
    parameter int unsigned NUM_SLAVES = 4
);
    logic [APERWIDTH-1:0]     WBs_ADR_i;
    logic                     WBs_CYC_i;
    logic                     WBs_STB_i;
    logic [31:0]              WBs_RD_DAT_o;
    logic                     WBs_ACK_o;
    logic                     WBs_ERR_o;
    logic [NUM_SLAVES-1:0]    WBs_CYC_o;
    logic [NUM_SLAVES-1:0]    WBs_ACK_i;
    logic [NUM_SLAVES*32-1:0] WBs_RD_DAT_i;

    modport slave (
        input  WBs_ADR_i, WBs_CYC_i, WBs_STB_i, WBs_ACK_i, WBs_RD_DAT_i,
        output WBs_RD_DAT_o, WBs_ACK_o, WBs_ERR_o, WBs_CYC_o
    );

    modport master (
        output WBs_ADR_i, WBs_CYC_i, WBs_STB_i, WBs_ACK_i, WBs_RD_DAT_i,
        input  WBs_RD_DAT_o, WBs_ACK_o, WBs_ERR_o, WBs_CYC_o
    );
endinterface

// File: rtl/al4s3b_fpga_wb_interconnect.sv
// Wishbone read interconnect: decodes one master onto NUM_SLAVES apertures,
// with ACK timeout, default read data on errors, and error status tracking.
module al4s3b_fpga_wb_interconnect #(
    parameter int unsigned                  APERWIDTH          = 17,
    parameter int unsigned                  APERSIZE           = 10,
    parameter int unsigned                  NUM_SLAVES         = 4,
    parameter logic [NUM_SLAVES*APERWIDTH-1:0] BASE_ADDRS      = {17'h05000, 17'h04000, 17'h03000, 17'h01000},
    parameter int unsigned                  TIMEOUT_CYCLES     = 255,
    parameter logic [31:0]                  DEFAULT_READ_VALUE = 32'hBADFABAC
) (
    input  logic                          WBs_CLK_i,
    input  logic                          WBs_RST_n_i,
    al4s3b_fpga_wb_interconnect_if.slave  bus,
    input  logic                          err_clr_i,
    output logic [15:0]                   err_count_o,
    output logic [APERWIDTH-1:0]          last_err_adr_o
);
    typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

    state_t                state_q, state_n;
    logic [NUM_SLAVES-1:0] cyc_q, cyc_n;
    logic [15:0]           wait_q, wait_n;
    logic [APERWIDTH-1:0]  adr_q, adr_n;
    logic [31:0]           dat_q, dat_n;
    logic                  ack_q, ack_n;
    logic                  err_q, err_n;
    logic [15:0]           err_count_q, err_count_n;
    logic [APERWIDTH-1:0]  last_err_adr_q, last_err_adr_n;

    logic [NUM_SLAVES-1:0] hit_oh;
    logic                  ack_hit;
    logic [31:0]           ack_dat;
    logic                  err_evt;
    logic [APERWIDTH-1:0]  err_adr;

    // Scan from the top index down so the lowest matching slave overwrites the rest.
    always_comb begin
        hit_oh = '0;
        for (int unsigned i = NUM_SLAVES; i > 0; i--) begin
            if (bus.WBs_ADR_i[APERWIDTH-1:APERSIZE] ==
                BASE_ADDRS[(i-1)*APERWIDTH + APERSIZE +: APERWIDTH-APERSIZE]) begin
                hit_oh        = '0;
                hit_oh[i-1]   = 1'b1;
            end
        end
    end

    // Selection follows the registered one-hot CYC_o, so foreign ACKs are masked out.
    always_comb begin
        ack_hit = |(bus.WBs_ACK_i & cyc_q);
        ack_dat = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (cyc_q[i]) ack_dat = ack_dat | bus.WBs_RD_DAT_i[i*32 +: 32];
        end
    end

    always_comb begin
        state_n = state_q;
        cyc_n   = cyc_q;
        wait_n  = wait_q;
        adr_n   = adr_q;
        dat_n   = dat_q;
        ack_n   = 1'b0;
        err_n   = 1'b0;
        err_evt = 1'b0;
        err_adr = adr_q;
        case (state_q)
            IDLE: begin
                if (bus.WBs_CYC_i && bus.WBs_STB_i) begin
                    adr_n = bus.WBs_ADR_i;
                    if (|hit_oh) begin
                        state_n = ACTIVE;
                        cyc_n   = hit_oh;
                        wait_n  = '0;
                    end else begin
                        state_n = RESP;
                        ack_n   = 1'b1;
                        err_n   = 1'b1;
                        dat_n   = DEFAULT_READ_VALUE;
                        err_evt = 1'b1;
                        err_adr = bus.WBs_ADR_i;
                    end
                end
            end
            ACTIVE: begin
                if (!bus.WBs_CYC_i) begin
                    state_n = IDLE;
                    cyc_n   = '0;
                end else if (ack_hit) begin
                    state_n = RESP;
                    cyc_n   = '0;
                    dat_n   = ack_dat;
                    ack_n   = 1'b1;
                end else if (wait_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    state_n = RESP;
                    cyc_n   = '0;
                    dat_n   = DEFAULT_READ_VALUE;
                    ack_n   = 1'b1;
                    err_n   = 1'b1;
                    err_evt = 1'b1;
                end else begin
                    wait_n  = wait_q + 16'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // A clear coinciding with a new error leaves exactly that error recorded.
    always_comb begin
        err_count_n    = err_count_q;
        last_err_adr_n = last_err_adr_q;
        if (err_clr_i) begin
            err_count_n    = err_evt ? 16'd1 : '0;
            last_err_adr_n = err_evt ? err_adr : '0;
        end else if (err_evt) begin
            if (err_count_q != '1) err_count_n = err_count_q + 16'd1;
            last_err_adr_n = err_adr;
        end
    end

    always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
        if (!WBs_RST_n_i) begin
            state_q        <= IDLE;
            cyc_q          <= '0;
            wait_q         <= '0;
            adr_q          <= '0;
            dat_q          <= '0;
            ack_q          <= 1'b0;
            err_q          <= 1'b0;
            err_count_q    <= '0;
            last_err_adr_q <= '0;
        end else begin
            state_q        <= state_n;
            cyc_q          <= cyc_n;
            wait_q         <= wait_n;
            adr_q          <= adr_n;
            dat_q          <= dat_n;
            ack_q          <= ack_n;
            err_q          <= err_n;
            err_count_q    <= err_count_n;
            last_err_adr_q <= last_err_adr_n;
        end
    end

    assign bus.WBs_CYC_o    = cyc_q;
    assign bus.WBs_RD_DAT_o = dat_q;
    assign bus.WBs_ACK_o    = ack_q;
    assign bus.WBs_ERR_o    = err_q;
    assign err_count_o      = err_count_q;
    assign last_err_adr_o   = last_err_adr_q;
endmodule
